decode_issue_stage: RTL and testbench

- Pipeline stage between the instruction decoder and the execute units.
- Takes per-instruction decoded control (register indices, read/write enables, halt, flush class) over a valid/ready handshake.
- Holds a one-entry output register and keeps separate scalar and vector scoreboards to block RAW/WAW hazards.
- Drains in-flight writes before cache flushes, latches halt, and keeps a saturating stall counter.

---
 rtl/decode_issue_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//
// Sits between the instruction decoder and the execute units. A decoded
// instruction is accepted over a valid/ready handshake into a one-entry output
// register, provided no RAW/WAW hazard exists against the scalar or vector
// scoreboards. Cache-flush instructions wait until every in-flight write has
// drained. A halt instruction latches a sticky halt that blocks further
// issue until reset. Cycles where an offered instruction is refused are
// counted in a saturating stall counter.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        decoder -> stage handshake
//   dec_r_read1/2, dec_v_read1/2  scalar / vector source use flags
//   dec_s_wr, dec_v_wr         scalar / vector destination write flags
//   dec_link                   scalar destination forced to LINK_REG
//   dec_rs1, dec_rs2, dec_rd   register indices (shared by both files)
//   dec_halt, dec_flush        halt / cache flush class
//   dec_payload                opaque control bits, passed through
//   out_valid / out_ready      stage -> execute handshake
//   out_payload, out_rd, out_halt, out_flush  registered issued entry
//   wb_s_valid/wb_s_idx        scalar writeback (clears scalar busy bit)
//   wb_v_valid/wb_v_idx        vector writeback (clears vector busy bit)
//   halted                     sticky halt
//   sb_err                     sticky: writeback to a register not busy
//   stall_cnt                  saturating count of refused offers
// -----------------------------------------------------------------------------
module decode_issue_stage #(
  parameter  int NREG     = 32,
  parameter  int CNT_W    = 16,
  parameter  int LINK_REG = 31,
  localparam int RW       = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dec_r_read1,
  input  logic             dec_r_read2,
  input  logic             dec_v_read1,
  input  logic             dec_v_read2,
  input  logic             dec_s_wr,
  input  logic             dec_v_wr,
  input  logic             dec_link,
  input  logic [RW-1:0]    dec_rs1,
  input  logic [RW-1:0]    dec_rs2,
  input  logic [RW-1:0]    dec_rd,
  input  logic             dec_halt,
  input  logic             dec_flush,
  input  logic [63:0]      dec_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_payload,
  output logic [RW-1:0]    out_rd,
  output logic             out_halt,
  output logic             out_flush,
  input  logic             wb_s_valid,
  input  logic [RW-1:0]    wb_s_idx,
  input  logic             wb_v_valid,
  input  logic [RW-1:0]    wb_v_idx,
  output logic             halted,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [RW-1:0]    LINK_IDX = RW'(LINK_REG);
  localparam logic [NREG-1:0]  ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_s_r;
  logic [NREG-1:0] busy_v_r;

  logic [NREG-1:0] wb_s_mask_s;
  logic [NREG-1:0] wb_v_mask_s;
  logic [NREG-1:0] pend_s_s;
  logic [NREG-1:0] pend_v_s;
  logic [NREG-1:0] set_s_mask_s;
  logic [NREG-1:0] set_v_mask_s;
  logic [NREG-1:0] busy_s_nxt_s;
  logic [NREG-1:0] busy_v_nxt_s;
  logic [RW-1:0]   erd_s;
  logic            hazard_s;
  logic            drain_block_s;
  logic            in_ready_s;
  logic            issue_s;
  logic            sb_err_hit_s;
  logic            stall_inc_s;

  // Hazard detection, issue decision and next scoreboard contents.
  always_comb begin
    wb_s_mask_s   = '0;
    wb_v_mask_s   = '0;
    set_s_mask_s  = '0;
    set_v_mask_s  = '0;
    erd_s         = dec_rd;

    if (wb_s_valid) begin
      wb_s_mask_s = ONE_HOT0 << wb_s_idx;
    end else begin
      wb_s_mask_s = '0;
    end
    if (wb_v_valid) begin
      wb_v_mask_s = ONE_HOT0 << wb_v_idx;
    end else begin
      wb_v_mask_s = '0;
    end

    // A writeback landing this cycle hides the busy bit (scoreboard bypass).
    pend_s_s = busy_s_r & ~wb_s_mask_s;
    pend_v_s = busy_v_r & ~wb_v_mask_s;

    if (dec_link) begin
      erd_s = LINK_IDX;
    end else begin
      erd_s = dec_rd;
    end

    hazard_s = (dec_r_read1 & pend_s_s[dec_rs1])
             | (dec_r_read2 & pend_s_s[dec_rs2])
             | (dec_v_read1 & pend_v_s[dec_rs1])
             | (dec_v_read2 & pend_v_s[dec_rs2])
             | (dec_s_wr    & pend_s_s[erd_s])
             | (dec_v_wr    & pend_v_s[dec_rd]);

    // Flushes wait until nothing is outstanding in either file.
    drain_block_s = dec_flush & ((|pend_s_s) | (|pend_v_s));

    in_ready_s = ~halted & (~out_valid | out_ready) & ~hazard_s & ~drain_block_s;
    issue_s    = in_valid & in_ready_s;

    if (issue_s && dec_s_wr) begin
      set_s_mask_s = ONE_HOT0 << erd_s;
    end else begin
      set_s_mask_s = '0;
    end
    if (issue_s && dec_v_wr) begin
      set_v_mask_s = ONE_HOT0 << dec_rd;
    end else begin
      set_v_mask_s = '0;
    end

    // Clear first, then set: a same-index set wins over a same-cycle clear.
    busy_s_nxt_s = (busy_s_r & ~wb_s_mask_s) | set_s_mask_s;
    busy_v_nxt_s = (busy_v_r & ~wb_v_mask_s) | set_v_mask_s;

    sb_err_hit_s = (wb_s_valid & ~busy_s_r[wb_s_idx])
                 | (wb_v_valid & ~busy_v_r[wb_v_idx]);

    stall_inc_s = in_valid & ~in_ready_s & ~halted & (stall_cnt != CNT_MAX);
  end

  assign in_ready = in_ready_s;

  // Scoreboards and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_s_r <= '0;
      busy_v_r <= '0;
      halted   <= 1'b0;
      sb_err   <= 1'b0;
    end else begin
      busy_s_r <= busy_s_nxt_s;
      busy_v_r <= busy_v_nxt_s;
      halted   <= halted | (issue_s & dec_halt);
      sb_err   <= sb_err | sb_err_hit_s;
    end
  end

  // One-entry output register: load on issue, drop on consume, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= 64'h0;
      out_rd      <= '0;
      out_halt    <= 1'b0;
      out_flush   <= 1'b0;
    end else if (issue_s) begin
      out_valid   <= 1'b1;
      out_payload <= dec_payload;
      out_rd      <= erd_s;
      out_halt    <= dec_halt;
      out_flush   <= dec_flush;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end else begin
      out_valid   <= out_valid;
    end
  end

  // Saturating count of cycles where an offered instruction was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_inc_s) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

  localparam int NREG  = 32;
  localparam int CNT_W = 16;
  localparam int RW    = 5;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready;
  logic          dec_r_read1, dec_r_read2, dec_v_read1, dec_v_read2;
  logic          dec_s_wr, dec_v_wr, dec_link, dec_halt, dec_flush;
  logic [RW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [63:0]   dec_payload;
  logic          out_valid, out_ready, out_halt, out_flush;
  logic [63:0]   out_payload;
  logic [RW-1:0] out_rd;
  logic          wb_s_valid, wb_v_valid;
  logic [RW-1:0] wb_s_idx, wb_v_idx;
  logic          halted, sb_err;
  logic [CNT_W-1:0] stall_cnt;

  decode_issue_stage #(.NREG(NREG), .CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dec_r_read1(dec_r_read1), .dec_r_read2(dec_r_read2),
    .dec_v_read1(dec_v_read1), .dec_v_read2(dec_v_read2),
    .dec_s_wr(dec_s_wr), .dec_v_wr(dec_v_wr), .dec_link(dec_link),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_halt(dec_halt), .dec_flush(dec_flush), .dec_payload(dec_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rd(out_rd), .out_halt(out_halt), .out_flush(out_flush),
    .wb_s_valid(wb_s_valid), .wb_s_idx(wb_s_idx),
    .wb_v_valid(wb_v_valid), .wb_v_idx(wb_v_idx),
    .halted(halted), .sb_err(sb_err), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy_s[NREG];
  bit          m_busy_v[NREG];
  bit          m_ov, m_oh, m_of, m_halted, m_sb_err;
  logic [63:0] m_pay;
  int          m_rd;
  int          m_stall;

  function automatic bit m_pend_s(input int i);
    return m_busy_s[i] && !(wb_s_valid && int'(wb_s_idx) == i);
  endfunction

  function automatic bit m_pend_v(input int i);
    return m_busy_v[i] && !(wb_v_valid && int'(wb_v_idx) == i);
  endfunction

  function automatic int m_erd();
    return dec_link ? 31 : int'(dec_rd);
  endfunction

  function automatic bit model_ready();
    if (m_halted) return 1'b0;
    if (m_ov && !out_ready) return 1'b0;
    if (dec_r_read1 && m_pend_s(int'(dec_rs1))) return 1'b0;
    if (dec_r_read2 && m_pend_s(int'(dec_rs2))) return 1'b0;
    if (dec_v_read1 && m_pend_v(int'(dec_rs1))) return 1'b0;
    if (dec_v_read2 && m_pend_v(int'(dec_rs2))) return 1'b0;
    if (dec_s_wr && m_pend_s(m_erd())) return 1'b0;
    if (dec_v_wr && m_pend_v(int'(dec_rd))) return 1'b0;
    if (dec_flush)
      for (int i = 0; i < NREG; i++)
        if (m_pend_s(i) || m_pend_v(i)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_busy_s[i] = 1'b0;
        m_busy_v[i] = 1'b0;
      end
      m_ov = 1'b0; m_oh = 1'b0; m_of = 1'b0; m_pay = 64'h0; m_rd = 0;
      m_halted = 1'b0; m_sb_err = 1'b0; m_stall = 0;
    end else begin
      automatic bit rdy   = model_ready();
      automatic bit issue = in_valid && rdy;
      automatic int erd   = m_erd();
      if (in_valid && !rdy && !m_halted && m_stall < CMAX) m_stall++;
      if (wb_s_valid) begin
        if (m_busy_s[wb_s_idx]) m_busy_s[wb_s_idx] = 1'b0; else m_sb_err = 1'b1;
      end
      if (wb_v_valid) begin
        if (m_busy_v[wb_v_idx]) m_busy_v[wb_v_idx] = 1'b0; else m_sb_err = 1'b1;
      end
      if (issue) begin
        if (dec_s_wr) m_busy_s[erd] = 1'b1;
        if (dec_v_wr) m_busy_v[dec_rd] = 1'b1;
        m_ov = 1'b1; m_pay = dec_payload; m_rd = erd;
        m_oh = dec_halt; m_of = dec_flush;
        if (dec_halt) m_halted = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, model_ready());
      chk("out_valid", out_valid, m_ov);
      chk("halted", halted, m_halted);
      chk("sb_err", sb_err, m_sb_err);
      chk("stall_cnt", stall_cnt, m_stall);
      if (m_ov) begin
        chk("out_payload", out_payload, m_pay);
        chk("out_rd", out_rd, m_rd);
        chk("out_halt", out_halt, m_oh);
        chk("out_flush", out_flush, m_of);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 1'b0; dec_r_read1 = 1'b0; dec_r_read2 = 1'b0;
    dec_v_read1 = 1'b0; dec_v_read2 = 1'b0; dec_s_wr = 1'b0; dec_v_wr = 1'b0;
    dec_link = 1'b0; dec_halt = 1'b0; dec_flush = 1'b0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_payload = 64'h0;
    wb_s_valid = 1'b0; wb_s_idx = 5'd0; wb_v_valid = 1'b0; wb_v_idx = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; clr();
    repeat (2) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);

    // Back-to-back independent scalar writes rd 1,2,3, then a link write.
    for (int r = 1; r <= 3; r++) begin
      clr(); in_valid = 1'b1; dec_s_wr = 1'b1; dec_rd = 5'(r);
      dec_payload = 64'h1000 + 64'(r);
      cyc();
      chk("b2b_rd", out_rd, 5'(r));
    end
    clr(); in_valid = 1'b1; dec_s_wr = 1'b1; dec_link = 1'b1; dec_rd = 5'd3;
    dec_payload = 64'h1004;
    cyc();
    chk("link_rd", out_rd, 5'd31);
    chk("b2b_stall", stall_cnt, 16'd0);
    clr(); cyc();
    chk("b2b_drained", out_valid, 1'b0);
    for (int r = 1; r <= 4; r++) begin
      dec_r_read1 = 1'b1; dec_rs1 = 5'(r); #1;
      chk("busy_probe", in_ready, (r == 4) ? 1'b1 : 1'b0);
    end
    clr();
    for (int r = 1; r <= 3; r++) begin
      wb_s_valid = 1'b1; wb_s_idx = 5'(r); cyc();
    end
    wb_s_idx = 5'd31; cyc();
    clr(); cyc();

    // Scalar RAW: write rd=5, reader rs1=5 stalls 3 cycles, issues on wb.
    in_valid = 1'b1; dec_s_wr = 1'b1; dec_rd = 5'd5; dec_payload = 64'h2005;
    cyc();
    clr(); in_valid = 1'b1; dec_r_read1 = 1'b1; dec_rs1 = 5'd5; dec_rd = 5'd6;
    dec_payload = 64'h2006;
    repeat (3) cyc();
    wb_s_valid = 1'b1; wb_s_idx = 5'd5; #1;
    chk("raw_bypass_ready", in_ready, 1'b1);
    cyc();
    chk("raw_issue_payload", out_payload, 64'h2006);
    chk("raw_stall", stall_cnt, 16'd3);
    clr(); cyc();

    // Vector WAW on rd=7.
    in_valid = 1'b1; dec_v_wr = 1'b1; dec_rd = 5'd7; dec_payload = 64'h3007;
    cyc();
    dec_payload = 64'h3008;
    repeat (2) cyc();
    chk("waw_stall", stall_cnt, 16'd5);
    wb_v_valid = 1'b1; wb_v_idx = 5'd7;
    cyc();
    chk("waw_issue_payload", out_payload, 64'h3008);
    clr(); dec_v_read1 = 1'b1; dec_rs1 = 5'd7; #1;
    chk("waw_busy_v7", in_ready, 1'b0);
    wb_v_valid = 1'b1; wb_v_idx = 5'd7; #1;
    chk("wb_v_bypass", in_ready, 1'b1);
    cyc();
    clr(); cyc();

    // Flush drain with scalar rd=4 and vector rd=9 outstanding.
    in_valid = 1'b1; dec_s_wr = 1'b1; dec_rd = 5'd4; cyc();
    clr(); in_valid = 1'b1; dec_v_wr = 1'b1; dec_rd = 5'd9; cyc();
    clr(); in_valid = 1'b1; dec_flush = 1'b1; dec_payload = 64'h4444;
    cyc();
    wb_s_valid = 1'b1; wb_s_idx = 5'd4; #1;
    chk("flush_wait_v", in_ready, 1'b0);
    cyc();
    wb_s_valid = 1'b0; wb_v_valid = 1'b1; wb_v_idx = 5'd9;
    cyc();
    chk("flush_issued", out_flush, 1'b1);
    chk("flush_stall", stall_cnt, 16'd7);
    clr(); cyc();

    // Writeback to an idle register.
    chk("sb_err_clean", sb_err, 1'b0);
    wb_s_valid = 1'b1; wb_s_idx = 5'd12; cyc();
    clr(); cyc();
    chk("sb_err_set", sb_err, 1'b1);
    dec_r_read1 = 1'b1; dec_rs1 = 5'd12; #1;
    chk("sb_err_sb_unchanged", in_ready, 1'b1);
    clr();

    // Saturation: output held by out_ready=0 while offers keep coming.
    out_ready = 1'b0; in_valid = 1'b1; dec_rd = 5'd8; dec_payload = 64'h7777;
    cyc();
    dec_payload = 64'h8888;
    repeat (70000) cyc();
    chk("stall_saturated", stall_cnt, 16'hFFFF);
    chk("held_payload", out_payload, 64'h7777);
    out_ready = 1'b1; clr(); cyc();

    // Halt, then a reset pulse in the middle of the stall.
    in_valid = 1'b1; dec_halt = 1'b1; dec_payload = 64'h9999; cyc();
    chk("halt_out", out_halt, 1'b1);
    chk("halt_flag", halted, 1'b1);
    clr(); in_valid = 1'b1; dec_payload = 64'hAAAA; #1;
    chk("halt_blocks", in_ready, 1'b0);
    repeat (3) cyc();
    chk("halt_consumed", out_valid, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_halted", halted, 1'b0);
    chk("async_rst_stall", stall_cnt, 16'd0);
    chk("async_rst_sb_err", sb_err, 1'b0);
    #1 rst_n = 1'b1;
    cyc();
    chk("post_rst_issue", out_payload, 64'hAAAA);
    clr(); cyc();

    // Halt with a scalar write: no counting while halted, writebacks still clear.
    in_valid = 1'b1; dec_halt = 1'b1; dec_s_wr = 1'b1; dec_rd = 5'd10; cyc();
    clr(); in_valid = 1'b1; repeat (4) cyc();
    chk("halted_no_count", stall_cnt, 16'd0);
    clr(); wb_s_valid = 1'b1; wb_s_idx = 5'd10; cyc();
    chk("halted_wb_clears", sb_err, 1'b0);
    cyc();
    chk("halted_wb_again_err", sb_err, 1'b1);
    clr(); cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
